trigger_conditioner: RTL and testbench
======================================

Name: trigger_conditioner

Overview:
Conditions the raw asynchronous target trigger before it reaches the glitch engine's enable logic. It synchronises the trigger, applies optional inversion and a programmable glitch-reject filter, then qualifies events by edge type and a programmable edge count. It produces a clean, held trigger level for the glitch engine. It sits between the board trigger pin and the top-level enable term, and its configuration comes from the cmd block registers.

Parameters:
SYNC_STAGES, 2, number of flops in the input synchroniser (minimum 2)
FILT_W, 16, width of the filter length and filter counter
CNT_W, 16, width of the edge target and edge counter

Ports:
clk  input  1  system clock (100 MHz PLL output)
rst  input  1  synchronous reset, active-high
trigger_in  input  1  raw asynchronous trigger from target
arm  input  1  level; high = conditioner armed (from cmd)
invert  input  1  invert trigger polarity; live, applied after synchroniser
mode  input  2  0 = level-high, 1 = rising, 2 = falling, 3 = both edges; latched at arm
filter_len  input  FILT_W  cycles the synced input must remain changed before being accepted; live
edge_target  input  CNT_W  qualifying events required to fire; latched at arm; 0 is treated as 1
trigger_out  output  1  conditioned trigger level to glitch enable
fired  output  1  high while in FIRED state
edge_count  output  CNT_W  qualifying events counted since arm
filt_level  output  1  filtered trigger level (for LED and debug)

Behaviour:
- Reset: all synchroniser flops, filt, filt_d, filter counter, edge_count, latched mode and target cleared; state = IDLE; trigger_out = 0, fired = 0, filt_level = 0.
- Synchroniser: SYNC_STAGES-flop chain. s = last stage XOR invert.
- Filter:
  - If s == filt, the counter clears.
  - If s != filt, the counter increments. When counter == filter_len, filt <= s and the counter clears.
  - filter_len = 0: filt <= s the next cycle, with no rejection.
  - A pulse shorter than filter_len+1 cycles never changes filt.
  - Pin-to-filt latency = SYNC_STAGES + filter_len + 1 cycles.
- Event detect: filt_d is filt delayed by one cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - ev = rise (mode 1), fall (mode 2), rise|fall (mode 3).
  - Mode 0 uses the level filt instead of ev.
- FSM states IDLE, COUNT, FIRED.
  - IDLE: edge_count = 0, trigger_out = 0. When arm = 1, latch mode and max(edge_target, 1), then go to COUNT. Events in the transition cycle are not counted.
  - COUNT:
    - arm = 0: go to IDLE and clear edge_count. This has priority over any same-cycle event.
    - Mode 0: if filt = 1, go to FIRED.
    - Modes 1–3: on ev, edge_count <= edge_count + 1. If edge_count + 1 == latched target, go to FIRED.
    - edge_count saturates at all-ones.
  - FIRED: trigger_out = 1 and fired = 1, registered, asserting the cycle after the qualifying event. Held until arm = 0, then go to IDLE the next cycle, where trigger_out drops. Further events are ignored; edge_count freezes.
- Mode 0 with filt already high when arm rises: enters COUNT, then FIRED one cycle later.
- Changing mode or edge_target while not in IDLE has no effect until the next arm.
- Changing invert mid-operation flips s. It passes through the filter like any input change and can create a real edge.
- rst asserted in any state: everything returns to reset values on the next clk edge, regardless of arm.
- filt_level = filt at all times. All outputs are registered.

Test Plan:
- Reset, arm = 0, toggle trigger_in -> trigger_out = 0, edge_count = 0, filt_level follows the pin with latency 3 (filter_len = 0).
- filter_len = 4, mode = 1, target = 1, arm: a 3-cycle high pulse -> no fire. A 6-cycle high pulse -> trigger_out = 1 at pulse start + 2 + 4 + 2 cycles, held until arm = 0.
- mode = 3, target = 5, filter_len = 0: drive 3 clean pulses (6 edges) -> edge_count reaches 5 on the fifth edge, trigger_out rises the next cycle, edge_count stays 5.
- mode = 2, invert = 1, target = 2: two rising pulses on the pin -> fires after the second pin rising edge (seen as falling); edge_count = 2.
- mode = 0, trigger_in held high before arm: arm -> FIRED two cycles after arm rises. arm low -> trigger_out = 0 the next cycle, edge_count = 0.
- mode = 1, target = 3: after 2 edges, drop arm in the same cycle as the third edge -> IDLE, edge_count = 0, no fire. Assert rst mid-COUNT -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronises the raw target trigger, applies optional
// inversion and a glitch-reject filter, then qualifies edges or level against
// an edge-count target. It holds a clean trigger level for the glitch enable.
module trigger_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger_in,
    input  logic              arm,
    input  logic              invert,
    input  logic [1:0]        mode,
    input  logic [FILT_W-1:0] filter_len,
    input  logic [CNT_W-1:0]  edge_target,
    output logic              trigger_out,
    output logic              fired,
    output logic [CNT_W-1:0]  edge_count,
    output logic              filt_level
);

    // A single-flop synchroniser is never safe, so a short chain is silently lengthened.
    localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StFired
    } state_e;

    logic [Stages-1:0] sync_q, sync_d;
    logic              s;

    logic              filt_q, filt_d;
    logic              filt_dly_q;
    logic [FILT_W-1:0] fcnt_q, fcnt_d;

    logic              rise, fall, ev;
    logic [CNT_W-1:0]  cnt_inc;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fired_q;

    // Synchroniser shift: new pin sample enters at bit 0, oldest sits at the top.
    always_comb begin
        sync_d = {sync_q[Stages-2:0], trigger_in};
    end

    // Invert is applied after synchronisation so a live change is seen as an input edge.
    always_comb begin
        s = sync_q[Stages-1] ^ invert;
    end

    // Glitch filter: accept a new level only after it has disagreed with filt for
    // filter_len+1 consecutive cycles; any agreement restarts the count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (s != filt_q) begin
            if (fcnt_q == filter_len) begin
                filt_d = s;
            end else begin
                fcnt_d = fcnt_q + FILT_W'(1);
            end
        end
    end

    // Edge qualification against the mode latched at arm.
    always_comb begin
        rise = filt_q & ~filt_dly_q;
        fall = ~filt_q & filt_dly_q;
        case (mode_q)
            2'd1:    ev = rise;
            2'd2:    ev = fall;
            2'd3:    ev = rise | fall;
            default: ev = 1'b0;
        endcase
    end

    // Saturating increment so a huge event burst can never wrap the count.
    always_comb begin
        cnt_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    end

    // FSM next state: disarm always wins over a same-cycle event.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        count_d  = count_q;
        case (state_q)
            StIdle: begin
                count_d = '0;
                if (arm) begin
                    mode_d   = mode;
                    target_d = (edge_target == '0) ? CNT_W'(1) : edge_target;
                    state_d  = StCount;
                end
            end
            StCount: begin
                if (!arm) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (mode_q == 2'd0) begin
                    if (filt_q) begin
                        state_d = StFired;
                    end
                end else if (ev) begin
                    count_d = cnt_inc;
                    if (cnt_inc == target_q) begin
                        state_d = StFired;
                    end
                end
            end
            StFired: begin
                if (!arm) begin
                    state_d = StIdle;
                    count_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    // All state, with synchronous reset; the fired flop tracks the next FSM state
    // so the output rises together with the FIRED state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            fcnt_q     <= '0;
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            target_q   <= '0;
            count_q    <= '0;
            fired_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            count_q    <= count_d;
            fired_q    <= (state_d == StFired);
        end
    end

    // Outputs straight from registers.
    always_comb begin
        trigger_out = fired_q;
        fired       = fired_q;
        edge_count  = count_q;
        filt_level  = filt_q;
    end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: a vector table, hand-written corner sequences
// and a randomized run, all checked every cycle against a behavioural model.
module tb_trigger_conditioner;

    localparam int SS   = 2;
    localparam int FW   = 16;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger_in;
    logic          arm;
    logic          invert;
    logic [1:0]    mode;
    logic [FW-1:0] filter_len;
    logic [CW-1:0] edge_target;
    logic          trigger_out;
    logic          fired;
    logic [CW-1:0] edge_count;
    logic          filt_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trigger_conditioner #(
        .SYNC_STAGES(SS),
        .FILT_W     (FW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger_in (trigger_in),
        .arm        (arm),
        .invert     (invert),
        .mode       (mode),
        .filter_len (filter_len),
        .edge_target(edge_target),
        .trigger_out(trigger_out),
        .fired      (fired),
        .edge_count (edge_count),
        .filt_level (filt_level)
    );

    // Reference model: pin history queue, "cycles disagreeing" run length,
    // and an armed/done view of the qualification.
    bit   pipe[$];
    bit   m_filt, m_filt_prev;
    int   m_run, m_phase, m_count, m_tgt;
    int   m_mode;

    function automatic void model_step();
        bit s, rise, fall, ev;
        if (rst) begin
            pipe = {};
            repeat (SS) pipe.push_back(1'b0);
            m_filt = 0; m_filt_prev = 0; m_run = 0;
            m_phase = 0; m_count = 0; m_tgt = 1; m_mode = 0;
            return;
        end
        s    = pipe[0] ^ invert;
        rise = m_filt && !m_filt_prev;
        fall = !m_filt && m_filt_prev;
        ev   = (m_mode == 1) ? rise : (m_mode == 2) ? fall : (m_mode == 3) ? (rise || fall) : 1'b0;
        if (m_phase == 0) begin
            m_count = 0;
            if (arm) begin
                m_mode  = int'(mode);
                m_tgt   = (edge_target == 0) ? 1 : int'(edge_target);
                m_phase = 1;
            end
        end else if (!arm) begin
            m_phase = 0;
            m_count = 0;
        end else if (m_phase == 1) begin
            if (m_mode == 0) begin
                if (m_filt) m_phase = 2;
            end else if (ev) begin
                if (m_count < CMAX) m_count++;
                if (m_count == m_tgt) m_phase = 2;
            end
        end
        m_filt_prev = m_filt;
        if (s == m_filt) m_run = 0;
        else if (m_run == int'(filter_len)) begin
            m_filt = s;
            m_run  = 0;
        end else m_run++;
        void'(pipe.pop_front());
        pipe.push_back(trigger_in);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model_trigger_out", {31'b0, trigger_out}, (m_phase == 2) ? 1 : 0);
        chk("model_fired", {31'b0, fired}, (m_phase == 2) ? 1 : 0);
        chk("model_edge_count", {16'b0, edge_count}, m_count);
        chk("model_filt_level", {31'b0, filt_level}, {31'b0, m_filt});
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0; trigger_in = 1'b0; invert = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        bit r, p, a;
        int m, t;
        bit e_trig, e_fired;
        int e_cnt;
        bit e_filt;
    } vec_t;

    function automatic vec_t v(bit r, bit p, bit a, int m, int t, bit et, bit ef, int ec,
                               bit el);
        vec_t x;
        x.r = r; x.p = p; x.a = a; x.m = m; x.t = t;
        x.e_trig = et; x.e_fired = ef; x.e_cnt = ec; x.e_filt = el;
        return x;
    endfunction

    vec_t tbl[12];

    initial begin
        rst = 1'b1; trigger_in = 1'b0; arm = 1'b0; invert = 1'b0;
        mode = 2'd0; filter_len = '0; edge_target = CW'(1);

        // filter_len = 0: filt follows the pin 3 edges later; then a rising fire.
        tbl[0]  = v(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = v(0, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = v(0, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[4]  = v(0, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[5]  = v(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[6]  = v(0, 1, 1, 1, 1, 0, 0, 0, 0);
        tbl[7]  = v(0, 1, 1, 1, 1, 0, 0, 0, 0);
        tbl[8]  = v(0, 1, 1, 1, 1, 0, 0, 0, 1);
        tbl[9]  = v(0, 1, 1, 1, 1, 1, 1, 1, 1);
        tbl[10] = v(0, 1, 0, 1, 1, 0, 0, 0, 1);
        tbl[11] = v(1, 1, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].r; trigger_in = tbl[i].p; arm = tbl[i].a;
            mode = 2'(tbl[i].m); edge_target = CW'(tbl[i].t);
            cyc();
            chk($sformatf("tbl%0d_trigger_out", i), {31'b0, trigger_out}, {31'b0, tbl[i].e_trig});
            chk($sformatf("tbl%0d_fired", i), {31'b0, fired}, {31'b0, tbl[i].e_fired});
            chk($sformatf("tbl%0d_edge_count", i), {16'b0, edge_count}, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_filt_level", i), {31'b0, filt_level}, {31'b0, tbl[i].e_filt});
        end

        // Filter reject: 3-cycle pulse rejected, 6-cycle pulse fires 8 edges after start.
        do_reset();
        filter_len = FW'(4); mode = 2'd1; edge_target = CW'(1); arm = 1'b1;
        cyc(); cyc();
        for (int i = 0; i < 14; i++) begin
            trigger_in = (i < 3);
            cyc();
        end
        chk("short_pulse_no_fire", {31'b0, trigger_out}, 0);
        chk("short_pulse_filt", {31'b0, filt_level}, 0);
        for (int i = 1; i <= 20; i++) begin
            trigger_in = (i <= 6);
            cyc();
            if (i == 7) chk("long_pulse_before", {31'b0, trigger_out}, 0);
            if (i == 8) chk("long_pulse_fire", {31'b0, trigger_out}, 1);
        end
        chk("long_pulse_held", {31'b0, trigger_out}, 1);
        arm = 1'b0;
        cyc();
        chk("long_pulse_disarm", {31'b0, trigger_out}, 0);

        // Both edges, target 5: fires with count 5 and the count freezes.
        do_reset();
        filter_len = '0; mode = 2'd3; edge_target = CW'(5); arm = 1'b1;
        cyc();
        for (int i = 0; i < 24; i++) begin
            trigger_in = ((i % 6) < 3);
            cyc();
            if (i == 14) chk("both_cnt4", {16'b0, edge_count}, 4);
            if (i == 14) chk("both_not_yet", {31'b0, trigger_out}, 0);
            if (i == 15) chk("both_cnt5", {16'b0, edge_count}, 5);
            if (i == 15) chk("both_fire", {31'b0, trigger_out}, 1);
        end
        chk("both_cnt_frozen", {16'b0, edge_count}, 5);
        arm = 1'b0;
        cyc();

        // Falling mode with inversion: pin rising edges are the qualifying events.
        do_reset();
        invert = 1'b1; filter_len = '0;
        repeat (5) cyc();
        mode = 2'd2; edge_target = CW'(2); arm = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            trigger_in = ((i % 6) < 3);
            cyc();
            if (i == 8) chk("inv_cnt1", {16'b0, edge_count}, 1);
            if (i == 8) chk("inv_not_yet", {31'b0, trigger_out}, 0);
            if (i == 9) chk("inv_fire", {31'b0, trigger_out}, 1);
        end
        chk("inv_cnt2", {16'b0, edge_count}, 2);

        // Level mode with the pin already high: FIRED two edges after arm.
        do_reset();
        trigger_in = 1'b1; mode = 2'd0;
        repeat (5) cyc();
        arm = 1'b1;
        cyc();
        chk("lvl_first", {31'b0, fired}, 0);
        cyc();
        chk("lvl_fired", {31'b0, fired}, 1);
        chk("lvl_trig", {31'b0, trigger_out}, 1);
        arm = 1'b0;
        cyc();
        chk("lvl_drop", {31'b0, trigger_out}, 0);
        chk("lvl_cnt0", {16'b0, edge_count}, 0);

        // Disarm on the same cycle as the final edge wins; then reset mid-COUNT.
        do_reset();
        mode = 2'd1; edge_target = CW'(3); arm = 1'b1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            trigger_in = ((i % 4) < 2);
            arm = (i < 11);
            cyc();
            if (i == 10) chk("race_cnt2", {16'b0, edge_count}, 2);
            if (i == 11) chk("race_cnt0", {16'b0, edge_count}, 0);
        end
        chk("race_no_fire", {31'b0, trigger_out}, 0);
        trigger_in = 1'b0; arm = 1'b1;
        cyc();
        trigger_in = 1'b1;
        repeat (5) cyc();
        chk("rst_pre_cnt1", {16'b0, edge_count}, 1);
        rst = 1'b1;
        cyc();
        chk("rst_trig", {31'b0, trigger_out}, 0);
        chk("rst_cnt", {16'b0, edge_count}, 0);
        chk("rst_filt", {31'b0, filt_level}, 0);
        rst = 1'b0;

        // Randomized run; filter_len only changes while in reset.
        for (int seg = 0; seg < 20; seg++) begin
            rst = 1'b1; arm = 1'b0; trigger_in = 1'b0;
            filter_len  = FW'($urandom_range(0, 3));
            invert      = 1'($urandom_range(0, 1));
            mode        = 2'($urandom_range(0, 3));
            edge_target = CW'($urandom_range(0, 3));
            cyc();
            rst = 1'b0;
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 3) == 0) trigger_in = ~trigger_in;
                if ($urandom_range(0, 29) == 0) arm = ~arm;
                if ($urandom_range(0, 49) == 0) invert = ~invert;
                if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) edge_target = CW'($urandom_range(0, 3));
                rst = ($urandom_range(0, 199) == 0);
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
